// File: rtl/audio_pkg.sv
// Shared types and arithmetic helpers for the audio effects / tone generator.
package audio_pkg;

  typedef enum logic [1:0] {
    SILENT = 2'd0,
    SINE   = 2'd1,
    PASS   = 2'd2,
    ECHO   = 2'd3
  } audio_mode_t;

  // Adds two sign-extended operands and clamps the result to the signed range of w bits (w <= 32).
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int w);
    logic signed [32:0] s;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    s  = 33'(a) + 33'(b);
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    if (s > hi) begin
      s = hi;
    end else if (s < lo) begin
      s = lo;
    end
    return 32'(s);
  endfunction

endpackage

// File: rtl/audio_effects_gen_sine_lut.sv
// Full-period sine ROM, amplitude 2^(W-1)-1, rounded to nearest; combinational read.
module sine_lut #(
  parameter int W      = 16,
  parameter int LUT_AW = 8
) (
  input  logic [LUT_AW-1:0] addr,
  output logic [W-1:0]      data
);

  localparam int  N      = 1 << LUT_AW;
  localparam real TWO_PI = 6.283185307179586;
  localparam real AMP    = (1 << (W - 1)) - 1;

  logic [W-1:0] table_q [N];

  // Table contents are constants resolved at elaboration, so this maps to a ROM.
  for (genvar i = 0; i < N; i++) begin : g_tab
    localparam real X = AMP * $sin(TWO_PI * i / N);
    localparam int  V = (X >= 0.0) ? $rtoi(X + 0.5) : -$rtoi(0.5 - X);
    assign table_q[i] = W'(V);
  end

  assign data = table_q[addr];

endmodule

// File: rtl/audio_effects_gen.sv
// DDS sine / passthrough / echo source feeding one attenuated output register, strobed by sample_req.
module audio_effects_gen
  import audio_pkg::*;
#(
  parameter int W           = 16,
  parameter int PHASE_W     = 16,
  parameter int LUT_AW      = 8,
  parameter int DELAY_DEPTH = 1024,
  parameter int ECHO_SHIFT  = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sample_end,
  input  logic               sample_req,
  input  logic [W-1:0]       audio_input,
  input  logic [1:0]         mode,
  input  logic [PHASE_W-1:0] phase_step,
  input  logic [1:0]         atten,
  output logic [W-1:0]       audio_output,
  output logic               out_valid
);

  localparam int DAW    = (DELAY_DEPTH > 1) ? $clog2(DELAY_DEPTH) : 1;
  localparam int FILL_W = $clog2(DELAY_DEPTH + 1);

  logic [PHASE_W-1:0]       phase;
  logic signed [W-1:0]      last_sample;
  logic signed [W-1:0]      delayed;
  logic [DAW-1:0]           wptr;
  logic [FILL_W-1:0]        fill;
  logic [W-1:0]             mem [DELAY_DEPTH];

  logic [W-1:0]             lut_p0;
  logic signed [W-1:0]      raw_p0;
  audio_mode_t              mode_p0;

  function automatic logic signed [W-1:0] echo_mix(input logic signed [W-1:0] a,
                                                   input logic signed [W-1:0] d);
    logic signed [W-1:0] d_sh;
    logic signed [31:0]  s;
    d_sh = d >>> ECHO_SHIFT;
    s    = sat_add(32'(a), 32'(d_sh), W);
    return W'(s);
  endfunction

  sine_lut #(
    .W      (W),
    .LUT_AW (LUT_AW)
  ) u_lut (
    .addr (phase[PHASE_W-1 -: LUT_AW]),
    .data (lut_p0)
  );

  assign mode_p0 = audio_mode_t'(mode);

  // Stage p0: pick the raw sample from the current source.
  always_comb begin
    raw_p0 = '0;
    case (mode_p0)
      SILENT:  raw_p0 = '0;
      SINE:    raw_p0 = lut_p0;
      PASS:    raw_p0 = last_sample;
      ECHO:    raw_p0 = echo_mix(last_sample, delayed);
      default: raw_p0 = '0;
    endcase
  end

  // Delay line storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (sample_end) begin
      mem[wptr] <= audio_input;
    end
  end

  // Capture side: delayed reads the old RAM word at wptr before it is overwritten.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_sample <= '0;
      delayed     <= '0;
      wptr        <= '0;
      fill        <= '0;
    end else if (sample_end) begin
      last_sample <= audio_input;
      delayed     <= (fill == FILL_W'(DELAY_DEPTH)) ? mem[wptr] : '0;
      wptr        <= (wptr == DAW'(DELAY_DEPTH - 1)) ? '0 : wptr + 1'b1;
      if (fill != FILL_W'(DELAY_DEPTH)) begin
        fill <= fill + 1'b1;
      end
    end
  end

  // Stage p1: registered, attenuated output and its one-cycle valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase        <= '0;
      audio_output <= '0;
      out_valid    <= 1'b0;
    end else begin
      out_valid <= sample_req;
      if (sample_req) begin
        audio_output <= raw_p0 >>> atten;
        if (mode_p0 == SINE) begin
          phase <= phase + phase_step;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_effects_gen.sv
// Scoreboard bench for audio_effects_gen with a 4-sample echo line.
module tb_audio_effects_gen;

  localparam int W  = 16;
  localparam int DD = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          sample_end;
  logic          sample_req;
  logic [W-1:0]  audio_input;
  logic [1:0]    mode;
  logic [15:0]   phase_step;
  logic [1:0]    atten;
  logic [W-1:0]  audio_output;
  logic          out_valid;

  typedef struct { string name; logic [15:0] exp; } exp_t;
  typedef struct { string name; logic [15:0] act; logic [15:0] exp; } dir_t;

  exp_t sq[$];
  dir_t dq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   done   = 1'b0;

  always #5 clk = ~clk;

  audio_effects_gen #(
    .W           (W),
    .PHASE_W     (16),
    .LUT_AW      (8),
    .DELAY_DEPTH (DD),
    .ECHO_SHIFT  (1)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_end   (sample_end),
    .sample_req   (sample_req),
    .audio_input  (audio_input),
    .mode         (mode),
    .phase_step   (phase_step),
    .atten        (atten),
    .audio_output (audio_output),
    .out_valid    (out_valid)
  );

  function automatic logic [15:0] lut_model(input int i);
    real x;
    x = 32767.0 * $sin(2.0 * 3.141592653589793 * i / 256.0);
    if (x >= 0.0) return 16'($rtoi(x + 0.5));
    return 16'(-$rtoi(0.5 - x));
  endfunction

  // Monitor: drains direct checks, scores every out_valid, ends the run.
  always @(negedge clk) begin
    dir_t d;
    exp_t e;
    cyc++;
    while (dq.size() > 0) begin
      d = dq.pop_front();
      checks++;
      if (d.act !== d.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", d.name, d.act, d.exp);
      end
    end
    if (reset_n && out_valid) begin
      checks++;
      if (sq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got out_valid=1 with output %h, expected no valid", audio_output);
      end else begin
        e = sq.pop_front();
        if (audio_output !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, audio_output, e.exp);
        end
      end
    end
    if (done || cyc > 20000) begin
      if (cyc > 20000) begin
        errors++;
        $display("FAIL watchdog: got %0d cycles, expected completion", cyc);
      end
      if (sq.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL missing_valid: got %0d outstanding, expected 0", sq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [1:0] m, input logic [1:0] a, input logic [15:0] exp, input string nm);
    mode       = m;
    atten      = a;
    sample_req = 1'b1;
    sq.push_back('{nm, exp});
    tick();
    sample_req = 1'b0;
    tick();
  endtask

  task automatic samp(input logic [15:0] v);
    audio_input = v;
    sample_end  = 1'b1;
    tick();
    sample_end  = 1'b0;
  endtask

  task automatic mid_reset(input string nm);
    #2;
    reset_n = 1'b0;
    #1;
    dq.push_back('{nm, audio_output, 16'h0000});
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    reset_n     = 1'b0;
    sample_end  = 1'b0;
    sample_req  = 1'b0;
    audio_input = '0;
    mode        = 2'd0;
    phase_step  = 16'h0100;
    atten       = 2'd0;
    tick();
    tick();
    dq.push_back('{"rst_output", audio_output, 16'h0000});
    dq.push_back('{"rst_valid", {15'b0, out_valid}, 16'h0000});
    reset_n = 1'b1;
    tick();

    req(2'd0, 2'd0, 16'h0000, "silent");
    dq.push_back('{"valid_pulse", {15'b0, out_valid}, 16'h0000});

    // Back-to-back SINE requests across a full period plus one.
    mode       = 2'd1;
    atten      = 2'd0;
    phase_step = 16'h0100;
    sample_req = 1'b1;
    for (int k = 0; k <= 256; k++) begin
      logic [15:0] ev;
      case (k % 256)
        0, 128:  ev = 16'h0000;
        64:      ev = 16'h7FFF;
        192:     ev = 16'h8001;
        default: ev = lut_model(k % 256);
      endcase
      sq.push_back('{"sine", ev});
      tick();
    end
    sample_req = 1'b0;
    tick();

    samp(16'h1234);
    req(2'd2, 2'd0, 16'h1234, "pass");
    audio_input = 16'h5555;
    sample_end  = 1'b1;
    mode        = 2'd2;
    sample_req  = 1'b1;
    sq.push_back('{"pass_same_cycle", 16'h1234});
    tick();
    sample_end  = 1'b0;
    sample_req  = 1'b0;
    tick();
    req(2'd2, 2'd0, 16'h5555, "pass_after");
    req(2'd1, 2'd0, 16'h0324, "phase_hold");

    samp(16'h8000);
    req(2'd2, 2'd2, 16'hE000, "atten2");
    req(2'd2, 2'd3, 16'hF000, "atten3");

    mid_reset("reset_out_a");
    samp(16'h1000); req(2'd3, 2'd0, 16'h1000, "echo_fill");
    for (int i = 0; i < 3; i++) begin
      samp(16'h0000); req(2'd3, 2'd0, 16'h0000, "echo_fill");
    end
    samp(16'h0000); req(2'd3, 2'd0, 16'h0800, "echo_tap");

    mid_reset("reset_out_b");
    for (int i = 1; i <= 13; i++) begin
      logic [15:0] v;
      logic [15:0] ev;
      v  = (i <= 5) ? 16'h7000 : 16'h9000;
      ev = (i <= 4) ? 16'h7000 : (i == 5) ? 16'h7FFF : (i <= 9) ? 16'hC800 : 16'h8000;
      samp(v);
      req(2'd3, 2'd0, ev, "echo_sat");
    end

    mid_reset("reset_out_c");
    for (int i = 0; i < DD; i++) begin
      samp(16'h2000); req(2'd3, 2'd0, 16'h2000, "echo_silent_after_reset");
    end
    samp(16'h0000); req(2'd3, 2'd0, 16'h1000, "echo_refilled");
    req(2'd0, 2'd1, 16'h0000, "silent_atten");

    tick();
    tick();
    done = 1'b1;
  end

endmodule
